// File: rtl/clic_vector_pkg.sv
// Shared types and constants for the CLIC vector fetch unit.
package clic_vector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } clic_vector_state_type;

  localparam int unsigned TBL_ALIGN_BITS = 6;

  // Table base is forced to a 64-byte boundary; each entry is one 32-bit word.
  function automatic logic [31:0] vec_entry_addr(input logic [31:0] mtvt,
                                                 input logic [11:0] id);
    logic [31:0] base;
    base = mtvt & ~((32'd1 << TBL_ALIGN_BITS) - 32'd1);
    return base + {18'd0, id, 2'b00};
  endfunction

endpackage

// File: rtl/clic_vector_cache.sv
// Single-entry handler-PC cache {valid, id, mtvt, pc}; only built with CLIC_VECTOR_CACHE_EN.
module clic_vector_cache
  import clic_vector_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] lookup_id_i,
  input  logic [31:0] lookup_mtvt_i,
  output logic        hit_o,
  output logic [31:0] hit_pc_o,
  input  logic        fill_i,
  input  logic [11:0] fill_id_i,
  input  logic [31:0] fill_mtvt_i,
  input  logic [31:0] fill_pc_i
);

  logic        valid_q;
  logic [11:0] id_q;
  logic [31:0] mtvt_q;
  logic [31:0] pc_q;
  logic [31:0] seen_mtvt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      id_q        <= '0;
      mtvt_q      <= '0;
      pc_q        <= '0;
      seen_mtvt_q <= '0;
    end else begin
      seen_mtvt_q <= lookup_mtvt_i;
      // A table move wins over a concurrent refill: the fetched word may be stale.
      if (lookup_mtvt_i != seen_mtvt_q) begin
        valid_q <= 1'b0;
      end else if (fill_i) begin
        valid_q <= 1'b1;
        id_q    <= fill_id_i;
        mtvt_q  <= fill_mtvt_i;
        pc_q    <= fill_pc_i;
      end
    end
  end

  assign hit_o    = valid_q && (id_q == lookup_id_i) && (mtvt_q == lookup_mtvt_i);
  assign hit_pc_o = pc_q;

endmodule

// File: rtl/clic_vector.sv
// CLIC vector fetch: latches a pending interrupt id, reads its handler PC from the
// vector table over the data bus and presents it to the core. Optional CLIC_VECTOR_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for an enabled, pending, non-zero interrupt id
// REQ   | one-cycle bus read request to the table entry
// WAIT  | waiting for mem_ready
// DONE  | handler PC valid, held until vec_ack
module clic_vector
  import clic_vector_pkg::*;
(
  input  logic        reset,
  input  logic        clock,
  input  logic        vec_meip,
  input  logic [11:0] vec_meid,
  input  logic        vec_mie,
  input  logic [31:0] vec_mtvt,
  output logic        vec_valid,
  output logic [31:0] vec_pc,
  output logic [11:0] vec_id,
  input  logic        vec_ack,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  clic_vector_state_type state_q;
  logic [11:0] id_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        mem_valid_q;
  logic [31:0] addr_q;

  logic        irq_take_d;
  logic [31:0] fetch_addr_d;
  logic [31:0] fetched_pc_d;
  logic        cache_hit;
  logic [31:0] cache_pc;

  assign irq_take_d   = vec_meip && vec_mie && (vec_meid != 12'd0);
  assign fetch_addr_d = vec_entry_addr(vec_mtvt, vec_meid);
  assign fetched_pc_d = mem_rdata & 32'hFFFF_FFFE;

`ifdef CLIC_VECTOR_CACHE_EN
  logic [31:0] mtvt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtvt_q <= '0;
    end else if (state_q == ST_IDLE && irq_take_d) begin
      mtvt_q <= vec_mtvt;
    end
  end

  clic_vector_cache u_cache (
    .clock         (clock),
    .reset         (reset),
    .lookup_id_i   (vec_meid),
    .lookup_mtvt_i (vec_mtvt),
    .hit_o         (cache_hit),
    .hit_pc_o      (cache_pc),
    .fill_i        (state_q == ST_WAIT && mem_ready),
    .fill_id_i     (id_q),
    .fill_mtvt_i   (mtvt_q),
    .fill_pc_i     (fetched_pc_d)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_pc  = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (irq_take_d) begin
            id_q <= vec_meid;
            if (cache_hit) begin
              pc_q    <= cache_pc;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              mem_valid_q <= 1'b1;
              addr_q      <= fetch_addr_d;
              state_q     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          mem_valid_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_ready) begin
            pc_q    <= fetched_pc_d;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Leaving DONE always passes through IDLE before the next latch.
          if (vec_ack) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vec_valid = valid_q;
  assign vec_pc    = pc_q;
  assign vec_id    = id_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = addr_q;
  assign mem_instr = 1'b0;
  assign mem_wdata = '0;
  assign mem_wstrb = '0;

endmodule

// File: tb/tb_clic_vector.sv
// Self-checking bench for clic_vector: table vectors, hand sequences and a randomized
// run against a transaction-level model (cache modelled when CLIC_VECTOR_CACHE_EN is set).
module tb_clic_vector;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        vec_meip = 1'b0;
  logic [11:0] vec_meid = '0;
  logic        vec_mie = 1'b0;
  logic [31:0] vec_mtvt = '0;
  logic        vec_valid;
  logic [31:0] vec_pc;
  logic [11:0] vec_id;
  logic        vec_ack = 1'b0;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

`ifdef CLIC_VECTOR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  clic_vector dut (
    .reset     (reset),
    .clock     (clock),
    .vec_meip  (vec_meip),
    .vec_meid  (vec_meid),
    .vec_mie   (vec_mie),
    .vec_mtvt  (vec_mtvt),
    .vec_valid (vec_valid),
    .vec_pc    (vec_pc),
    .vec_id    (vec_id),
    .vec_ack   (vec_ack),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int mv_cnt   = 0;

  always @(posedge clock) begin
    if (mem_valid) mv_cnt <= mv_cnt + 1;
  end

  // Reference cache: remembers the last fetched entry, forgotten on table move or reset.
  bit          c_valid = 1'b0;
  logic [11:0] c_id    = '0;
  logic [31:0] c_mtvt  = '0;
  logic [31:0] c_pc    = '0;

  typedef struct {
    logic [11:0] id;
    logic [31:0] mtvt;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [31:0] exp_addr(input logic [31:0] mtvt, input logic [11:0] id);
    logic [31:0] r;
    r = (mtvt / 32'd64) * 32'd64 + {20'd0, id} * 32'd4;
    return r;
  endfunction

  function automatic logic [31:0] exp_pc(input logic [31:0] rdata);
    return rdata - (rdata % 32'd2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mtvt(input logic [31:0] v);
    if (v !== vec_mtvt) c_valid = 1'b0;
    vec_mtvt = v;
  endtask

  task automatic do_txn(input logic [11:0] id, input logic [31:0] rdata,
                        input logic [31:0] ea, input logic [31:0] epc_miss,
                        input int lat, input int hold, input bit disturb);
    bit          hit;
    logic [31:0] epc;
    int          mv0;
    hit = CACHE_EN && c_valid && (c_id == id) && (c_mtvt == vec_mtvt);
    epc = hit ? c_pc : epc_miss;
    mv0 = mv_cnt;
    vec_meid = id;
    vec_meip = 1'b1;
    vec_mie  = 1'b1;
    step();
    if (disturb) begin
      vec_meid = 12'h007;
      vec_meip = 1'($urandom);
      vec_mie  = 1'($urandom);
    end else begin
      vec_meip = 1'b0;
    end
    chk("mem_instr", mem_instr, 0);
    chk("mem_wdata", mem_wdata, 0);
    chk("mem_wstrb", mem_wstrb, 0);
    if (hit) begin
      chk("hit_no_req", mem_valid, 0);
    end else begin
      chk("req_pulse", mem_valid, 1);
      chk("req_addr", mem_addr, ea);
      chk("req_no_valid", vec_valid, 0);
      mem_ready = disturb;
      mem_rdata = ~rdata;
      vec_ack   = disturb;
      step();
      chk("req_one_cycle", mem_valid, 0);
      mem_ready = 1'b0;
      vec_ack   = 1'b0;
      repeat (lat) begin
        vec_ack = 1'($urandom);
        step();
        chk("wait_no_valid", vec_valid, 0);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      vec_ack   = 1'b0;
      step();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (CACHE_EN) begin
        c_valid = 1'b1;
        c_id    = id;
        c_mtvt  = vec_mtvt;
        c_pc    = epc;
      end
    end
    chk("done_valid", vec_valid, 1);
    chk("done_pc", vec_pc, epc);
    chk("done_id", {20'd0, vec_id}, {20'd0, id});
    chk("mem_read_count", mv_cnt - mv0, hit ? 0 : 1);
    repeat (hold) begin
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      step();
      chk("hold_valid", vec_valid, 1);
      chk("hold_pc", vec_pc, epc);
      chk("hold_id", {20'd0, vec_id}, {20'd0, id});
    end
    mem_ready = 1'b0;
    vec_meip  = 1'b1;
    vec_mie   = 1'b1;
    vec_meid  = id;
    vec_ack   = 1'b1;
    step();
    vec_ack  = 1'b0;
    vec_meip = 1'b0;
    chk("ack_clears_valid", vec_valid, 0);
    chk("ack_no_restart", mem_valid, 0);
    step();
  endtask

  initial begin
    logic [11:0] rid;
    logic [31:0] rdat;
    int          mv0;

    tbl[0] = '{12'h005, 32'h0000_1000, 32'h0000_2003, 32'h0000_1014, 32'h0000_2002};
    tbl[1] = '{12'hFFF, 32'hFFFF_FFC0, 32'h1234_5679, 32'h0000_3FBC, 32'h1234_5678};
    tbl[2] = '{12'h001, 32'h8000_003F, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEE};
    tbl[3] = '{12'h800, 32'h0000_0000, 32'h0000_0001, 32'h0000_2000, 32'h0000_0000};
    tbl[4] = '{12'h0AB, 32'h1234_5678, 32'hCAFE_F00D, 32'h1234_58EC, 32'hCAFE_F00C};

    vec_meip = 1'b1;
    vec_mie  = 1'b1;
    vec_meid = 12'h005;
    repeat (3) step();
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_pc", vec_pc, 0);
    chk("rst_vec_id", {20'd0, vec_id}, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    vec_meip = 1'b0;
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      set_mtvt(tbl[i].mtvt);
      do_txn(tbl[i].id, tbl[i].rdata, tbl[i].addr, tbl[i].pc, i, 1 + i, 1'b0);
    end

    // Masked or zero-id requests never start a fetch.
    mv0 = mv_cnt;
    vec_mie = 1'b0; vec_meip = 1'b1; vec_meid = 12'h003;
    repeat (5) step();
    chk("mie0_no_valid", vec_valid, 0);
    chk("mie0_no_req", mv_cnt - mv0, 0);
    vec_mie = 1'b1; vec_meid = 12'h000;
    repeat (5) step();
    chk("id0_no_valid", vec_valid, 0);
    chk("id0_no_req", mv_cnt - mv0, 0);
    vec_meip = 1'b0;
    step();

    // Repeat request for id 5 (cache hit when enabled), then table move.
    set_mtvt(32'h0000_1000);
    do_txn(12'h005, 32'h0000_2003, 32'h0000_1014, 32'h0000_2002, 1, 1, 1'b0);
    do_txn(12'h005, 32'h0000_2003, 32'h0000_1014, 32'h0000_2002, 2, 2, 1'b0);
    set_mtvt(32'h0000_2000);
    do_txn(12'h005, 32'h0000_4441, 32'h0000_2014, 32'h0000_4440, 1, 1, 1'b0);

    // Interrupt inputs change (id 5 -> 7) while the fetch is in flight.
    set_mtvt(32'h0000_4000);
    do_txn(12'h005, 32'h0000_6007, 32'h0000_4014, 32'h0000_6006, 3, 2, 1'b1);

    // Reset while waiting for the bus; the late mem_ready must be dropped.
    vec_meid = 12'h009; vec_meip = 1'b1; vec_mie = 1'b1;
    step();
    vec_meip = 1'b0;
    chk("rw_req_pulse", mem_valid, 1);
    chk("rw_req_addr", mem_addr, 32'h0000_4024);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rw_async_valid", vec_valid, 0);
    chk("rw_async_mem_valid", mem_valid, 0);
    chk("rw_async_mem_addr", mem_addr, 0);
    chk("rw_async_id", {20'd0, vec_id}, 0);
    chk("rw_async_pc", vec_pc, 0);
    step();
    reset = 1'b1;
    c_valid = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_7777;
    mv0 = mv_cnt;
    repeat (3) begin
      step();
      chk("rw_late_ready_valid", vec_valid, 0);
    end
    chk("rw_late_ready_no_req", mv_cnt - mv0, 0);
    mem_ready = 1'b0;
    // Back in IDLE with an empty cache: id 5 at the same table must fetch again.
    do_txn(12'h005, 32'h0000_8009, 32'h0000_4014, 32'h0000_8008, 0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if (($urandom % 3) == 0) begin
        case ($urandom % 4)
          0: set_mtvt(32'h0000_1000);
          1: set_mtvt(32'h0000_2000);
          2: set_mtvt(32'hFFFF_FFC0);
          default: set_mtvt($urandom);
        endcase
      end
      rid  = (($urandom % 2) == 0) ? 12'h005 : 12'($urandom_range(1, 4095));
      rdat = $urandom;
      do_txn(rid, rdat, exp_addr(vec_mtvt, rid), exp_pc(rdat),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
